// File: rtl/regfile_wb_scheduler_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler_if
//
// Purpose: bundles the issue, writeback and register-file signals of the
// writeback scheduler.
//
// Modports:
//   master - the environment: decode/issue, the ALU pipeline, the long unit,
//            and the register file (drives requests, observes results).
//   slave  - the scheduler itself.
//
// Handshake rules:
//   - Long-unit results transfer on a clock edge where lu_wb_valid and
//     lu_wb_ready are both 1.
//   - While lu_wb_valid=1 and lu_wb_ready=0, the long unit holds
//     lu_wb_rd/lu_wb_data steady.
//   - ALU results (alu_wb_valid) are always taken; they cannot be
//     back-pressured.
//   - An issue is accepted on an edge where issue_valid=1 and issue_stall=0.
// ---------------------------------------------------------------------------
interface regfile_wb_scheduler_if;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [63:0] alu_wb_data;
  logic        lu_wb_valid;
  logic [4:0]  lu_wb_rd;
  logic [63:0] lu_wb_data;
  logic        lu_wb_ready;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [63:0] write_data;
  logic [31:0] busy_mask;

  modport master (
    output issue_valid, issue_long, issue_rs1, issue_rs2, issue_rd,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output lu_wb_valid, lu_wb_rd, lu_wb_data,
    input  issue_stall, lu_wb_ready, RegWrite, rd, write_data, busy_mask
  );

  modport slave (
    input  issue_valid, issue_long, issue_rs1, issue_rs2, issue_rd,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  lu_wb_valid, lu_wb_rd, lu_wb_data,
    output issue_stall, lu_wb_ready, RegWrite, rd, write_data, busy_mask
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Purpose:
//   Arbitrates the register file's single write port between two sources:
//     - the in-order ALU/load pipeline, which has absolute priority;
//     - a long-latency unit, whose results wait in a small skid FIFO.
//   Tracks busy long-latency destinations and stalls issue on RAW/WAW
//   hazards against them, or when too many long ops are in flight.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset
//   wb     - regfile_wb_scheduler_if.slave, which carries:
//              - issue request and issue_stall;
//              - ALU writeback;
//              - long-unit writeback with lu_wb_ready;
//              - registered RegWrite/rd/write_data;
//              - busy_mask.
//   perf_stall_cycles, perf_conflict_cycles
//          - 16-bit saturating counters, present only when the
//            WB_SCHED_PERF_EN macro is defined.
//
// Parameters:
//   FIFO_DEPTH      - long-unit result FIFO entries (power of 2, >= 2)
//   MAX_OUTSTANDING - long ops allowed in flight (issued, not yet popped)
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_scheduler_if.slave  wb
`ifdef WB_SCHED_PERF_EN
  ,
  output logic [15:0]            perf_stall_cycles,
  output logic [15:0]            perf_conflict_cycles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  // Long-unit result FIFO. Pointers carry one extra wrap bit so that
  // full and empty can be told apart.
  logic [63:0] fifo_data [FIFO_DEPTH];
  logic [4:0]  fifo_rd   [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push = wb.lu_wb_valid && !fifo_full;

  // Emptiness is taken from registered pointers, so a result pushed this
  // cycle cannot be popped before the next cycle (no bypass path).
  assign pop  = !wb.alu_wb_valid && !fifo_empty;

  // Write-port selection for this cycle.
  logic        sel_valid;
  logic        sel_long;
  logic [4:0]  sel_rd;
  logic [63:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_long  = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = 64'd0;
    if (wb.alu_wb_valid) begin
      sel_valid = 1'b1;
      sel_rd    = wb.alu_wb_rd;
      sel_data  = wb.alu_wb_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_long  = 1'b1;
      sel_rd    = fifo_rd[rd_ptr[AW-1:0]];
      sel_data  = fifo_data[rd_ptr[AW-1:0]];
    end
  end

  // Registered write port. wr_long travels with the write to mark it as
  // long-unit sourced for the scoreboard clear.
  logic        reg_write;
  logic        wr_long;
  logic [4:0]  wr_rd;
  logic [63:0] wr_data;
  logic [31:0] busy;
  logic [CW-1:0] outstanding;

  logic        issue_stall;
  logic        long_accept;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign issue_stall = wb.issue_valid &&
                       (busy[wb.issue_rs1] || busy[wb.issue_rs2] ||
                        busy[wb.issue_rd] ||
                        (wb.issue_long && outstanding == CW'(MAX_OUTSTANDING)));
  assign long_accept = wb.issue_valid && !issue_stall && wb.issue_long;

  assign set_mask = (long_accept && wb.issue_rd != 5'd0) ? (32'd1 << wb.issue_rd) : 32'd0;
  assign clr_mask = (reg_write && wr_long) ? (32'd1 << wr_rd) : 32'd0;

  // FIFO storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr[AW-1:0]] <= wb.lu_wb_data;
      fifo_rd[wr_ptr[AW-1:0]]   <= wb.lu_wb_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      reg_write   <= 1'b0;
      wr_long     <= 1'b0;
      wr_rd       <= 5'd0;
      wr_data     <= 64'd0;
      busy        <= 32'd0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // x0 results are consumed but never written.
      reg_write <= sel_valid && (sel_rd != 5'd0);
      wr_long   <= sel_long && (sel_rd != 5'd0);
      if (sel_valid) begin
        wr_rd   <= sel_rd;
        wr_data <= sel_data;
      end

      // Clear first, then set: a same-register set wins. Bit 0 never sets.
      busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;

      case ({long_accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign wb.issue_stall = issue_stall;
  assign wb.lu_wb_ready = !fifo_full;
  assign wb.RegWrite    = reg_write;
  assign wb.rd          = wr_rd;
  assign wb.write_data  = wr_data;
  assign wb.busy_mask   = busy;

`ifdef WB_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles    <= 16'd0;
      perf_conflict_cycles <= 16'd0;
    end else begin
      if (issue_stall && perf_stall_cycles != 16'hFFFF)
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
      if (wb.alu_wb_valid && !fifo_empty && perf_conflict_cycles != 16'hFFFF)
        perf_conflict_cycles <= perf_conflict_cycles + 16'd1;
    end
  end
`endif

endmodule
